// File: rtl/nasti_ram_sim_if.sv
// nasti_channel: NASTI (AXI4) channel bundle between one master and one slave.
// Carries the AR/AW/W/R/B signals that nasti_ram_sim uses. The sideband fields
// lock/cache/prot/qos/region and the request user fields are left out because
// the RAM ignores them.
// Modports:
//    master : drives ar_*, aw_*, w_*, r_ready, b_ready
//    slave  : drives ar_ready, aw_ready, w_ready, r_*, b_*
interface nasti_channel #(
   parameter int ID_WIDTH   = 1,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 128,
   parameter int USER_WIDTH = 1
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ID_WIDTH-1:0]   ar_id;
   logic [ADDR_WIDTH-1:0] ar_addr;
   logic [7:0]            ar_len;
   logic [2:0]            ar_size;
   logic [1:0]            ar_burst;
   logic                  ar_valid;
   logic                  ar_ready;

   logic [ID_WIDTH-1:0]   aw_id;
   logic [ADDR_WIDTH-1:0] aw_addr;
   logic [7:0]            aw_len;
   logic [2:0]            aw_size;
   logic [1:0]            aw_burst;
   logic                  aw_valid;
   logic                  aw_ready;

   logic [DATA_WIDTH-1:0] w_data;
   logic [STRB_WIDTH-1:0] w_strb;
   logic                  w_last;
   logic                  w_valid;
   logic                  w_ready;

   logic [ID_WIDTH-1:0]   r_id;
   logic [DATA_WIDTH-1:0] r_data;
   logic [1:0]            r_resp;
   logic                  r_last;
   logic [USER_WIDTH-1:0] r_user;
   logic                  r_valid;
   logic                  r_ready;

   logic [ID_WIDTH-1:0]   b_id;
   logic [1:0]            b_resp;
   logic [USER_WIDTH-1:0] b_user;
   logic                  b_valid;
   logic                  b_ready;

   modport master (
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
      input  ar_ready,
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_valid,
      input  w_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready
   );

   modport slave (
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
      output ar_ready,
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_valid,
      output w_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready
   );
endinterface

// File: rtl/nasti_ram_sim.sv
// nasti_ram_sim: NASTI (AXI4) slave RAM with a byte-strobed memory array.
// Handles FIXED/INCR/WRAP bursts, narrow transfers, DECERR for beats beyond
// MEM_BYTES, SLVERR for illegal bursts, and a programmable read latency.
// One outstanding burst per direction; read and write sides run concurrently.
// Ports:
//    clk   : clock, rising edge
//    rstn  : synchronous active-low reset (memory contents are kept)
//    nasti : nasti_channel.slave bus
//
// state  | meaning
// R_IDLE | ar_ready=1, waiting for a read request
// R_WAIT | read latency beyond the first cycle
// R_DATA | r_valid=1, presenting the current read beat
// W_IDLE | aw_ready=1, W beats stalled until a write request arrives
// W_DATA | w_ready=1, accepting write beats
// W_RESP | b_valid=1 until b_ready
module nasti_ram_sim #(
   parameter int ID_WIDTH   = 1,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 128,
   parameter int USER_WIDTH = 1,
   parameter int MEM_BYTES  = 65536,
   parameter int READ_LAT   = 1
) (
   input logic         clk,
   input logic         rstn,
   nasti_channel.slave nasti
);
   localparam int STRB_W  = DATA_WIDTH / 8;
   localparam int LANE_AW = $clog2(STRB_W);
   localparam int MEM_AW  = $clog2(MEM_BYTES);
   localparam int WORDS   = MEM_BYTES / STRB_W;
   localparam int WAIT_W  = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;
   localparam logic [WAIT_W-1:0]     WAIT_INIT = WAIT_W'((READ_LAT > 1) ? READ_LAT - 2 : 0);
   localparam logic [2:0]            MAX_SIZE  = 3'(LANE_AW);
   localparam logic [ADDR_WIDTH-1:0] A_ONE     = ADDR_WIDTH'(1);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

   logic [DATA_WIDTH-1:0] mem [0:WORDS-1];

   rd_state_t             rd_state, rd_next;
   logic [ID_WIDTH-1:0]   rd_id;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [7:0]            rd_len, rd_cnt;
   logic [2:0]            rd_size;
   logic [1:0]            rd_burst;
   logic                  rd_bad;
   logic [WAIT_W-1:0]     rd_wait;
   logic [DATA_WIDTH-1:0] rd_data;

   wr_state_t             wr_state, wr_next;
   logic [ID_WIDTH-1:0]   wr_id;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [7:0]            wr_len, wr_cnt;
   logic [2:0]            wr_size;
   logic [1:0]            wr_burst;
   logic                  wr_bad;
   logic [1:0]            wr_resp;

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [7:0] len,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] step, inc, mask;
      step = A_ONE << size;
      inc  = a + step;
      // wrap boundary is (len+1)*step; only the legal wrap lengths matter
      case (len)
         8'd1:    mask = (step << 1) - A_ONE;
         8'd3:    mask = (step << 2) - A_ONE;
         8'd7:    mask = (step << 3) - A_ONE;
         8'd15:   mask = (step << 4) - A_ONE;
         default: mask = step - A_ONE;
      endcase
      case (burst)
         2'd1:    next_addr = inc;
         2'd2:    next_addr = (a & ~mask) | (inc & mask);
         default: next_addr = a;
      endcase
   endfunction

   function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
      logic wrap_len_ok;
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      burst_bad = (burst == 2'd3) || (size > MAX_SIZE) || ((burst == 2'd2) && !wrap_len_ok);
   endfunction

   function automatic logic [1:0] beat_resp(input logic [ADDR_WIDTH-1:0] a, input logic bad);
      if ((a >> MEM_AW) != '0)
         beat_resp = RESP_DECERR;
      else if (bad)
         beat_resp = RESP_SLVERR;
      else
         beat_resp = RESP_OKAY;
   endfunction

   // Errored beats read as zero; the master selects lanes on narrow reads.
   function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic bad);
      if (beat_resp(a, bad) == RESP_OKAY)
         beat_data = mem[a[MEM_AW-1:LANE_AW]];
      else
         beat_data = '0;
   endfunction

   // ---------------- read side ----------------
   logic ar_hs, r_hs, rd_last, ar_bad;
   logic [ADDR_WIDTH-1:0] rd_addr_nxt;

   assign ar_hs       = (rd_state == R_IDLE) && nasti.ar_valid;
   assign r_hs        = (rd_state == R_DATA) && nasti.r_ready;
   assign rd_last     = (rd_cnt == rd_len);
   assign ar_bad      = burst_bad(nasti.ar_len, nasti.ar_size, nasti.ar_burst);
   assign rd_addr_nxt = next_addr(rd_addr, rd_len, rd_size, rd_burst);

   always_ff @(posedge clk) begin
      if (!rstn)
         rd_state <= R_IDLE;
      else
         rd_state <= rd_next;
   end

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         R_IDLE: if (ar_hs) rd_next = (READ_LAT == 1) ? R_DATA : R_WAIT;
         R_WAIT: if (rd_wait == '0) rd_next = R_DATA;
         R_DATA: if (r_hs && rd_last) rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   // rd_data is registered so it holds steady during back-pressure and a
   // same-cycle write to the same word returns the pre-write contents.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_id    <= '0;
         rd_addr  <= '0;
         rd_len   <= '0;
         rd_size  <= '0;
         rd_burst <= '0;
         rd_cnt   <= '0;
         rd_bad   <= 1'b0;
         rd_wait  <= '0;
         rd_data  <= '0;
      end else begin
         case (rd_state)
            R_IDLE: if (ar_hs) begin
               rd_id    <= nasti.ar_id;
               rd_addr  <= nasti.ar_addr;
               rd_len   <= nasti.ar_len;
               rd_size  <= nasti.ar_size;
               rd_burst <= nasti.ar_burst;
               rd_cnt   <= '0;
               rd_bad   <= ar_bad;
               rd_wait  <= WAIT_INIT;
               if (READ_LAT == 1)
                  rd_data <= beat_data(nasti.ar_addr, ar_bad);
            end
            R_WAIT: begin
               if (rd_wait != '0)
                  rd_wait <= rd_wait - 1'b1;
               else
                  rd_data <= beat_data(rd_addr, rd_bad);
            end
            R_DATA: if (r_hs && !rd_last) begin
               rd_addr <= rd_addr_nxt;
               rd_cnt  <= rd_cnt + 8'd1;
               rd_data <= beat_data(rd_addr_nxt, rd_bad);
            end
            default: ;
         endcase
      end
   end

   assign nasti.ar_ready = (rd_state == R_IDLE);
   assign nasti.r_valid  = (rd_state == R_DATA);
   assign nasti.r_last   = (rd_state == R_DATA) && rd_last;
   assign nasti.r_id     = rd_id;
   assign nasti.r_data   = rd_data;
   assign nasti.r_resp   = (rd_state == R_DATA) ? beat_resp(rd_addr, rd_bad) : RESP_OKAY;
   assign nasti.r_user   = '0;

   // ---------------- write side ----------------
   logic       aw_hs, w_hs, wr_end, w_mismatch, mem_we;
   logic [1:0] w_beat_resp, w_resp_acc;

   assign aw_hs       = (wr_state == W_IDLE) && nasti.aw_valid;
   assign w_hs        = (wr_state == W_DATA) && nasti.w_valid;
   assign wr_end      = nasti.w_last || (wr_cnt == wr_len);
   assign w_mismatch  = nasti.w_last != (wr_cnt == wr_len);
   assign w_beat_resp = beat_resp(wr_addr, wr_bad);
   assign mem_we      = rstn && w_hs && (w_beat_resp == RESP_OKAY);

   // numeric max orders DECERR > SLVERR > OKAY
   always_comb begin
      w_resp_acc = wr_resp;
      if (w_beat_resp > w_resp_acc)
         w_resp_acc = w_beat_resp;
      if (w_mismatch && (RESP_SLVERR > w_resp_acc))
         w_resp_acc = RESP_SLVERR;
   end

   always_ff @(posedge clk) begin
      if (!rstn)
         wr_state <= W_IDLE;
      else
         wr_state <= wr_next;
   end

   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         W_IDLE: if (aw_hs) wr_next = W_DATA;
         W_DATA: if (w_hs && wr_end) wr_next = W_RESP;
         W_RESP: if (nasti.b_ready) wr_next = W_IDLE;
         default: wr_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_id    <= '0;
         wr_addr  <= '0;
         wr_len   <= '0;
         wr_size  <= '0;
         wr_burst <= '0;
         wr_cnt   <= '0;
         wr_bad   <= 1'b0;
         wr_resp  <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            wr_id    <= nasti.aw_id;
            wr_addr  <= nasti.aw_addr;
            wr_len   <= nasti.aw_len;
            wr_size  <= nasti.aw_size;
            wr_burst <= nasti.aw_burst;
            wr_cnt   <= '0;
            wr_bad   <= burst_bad(nasti.aw_len, nasti.aw_size, nasti.aw_burst);
            wr_resp  <= RESP_OKAY;
         end else if (w_hs) begin
            wr_addr <= next_addr(wr_addr, wr_len, wr_size, wr_burst);
            wr_cnt  <= wr_cnt + 8'd1;
            wr_resp <= w_resp_acc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (nasti.w_strb[b])
               mem[wr_addr[MEM_AW-1:LANE_AW]][b*8 +: 8] <= nasti.w_data[b*8 +: 8];
         end
      end
   end

   assign nasti.aw_ready = (wr_state == W_IDLE);
   assign nasti.w_ready  = (wr_state == W_DATA);
   assign nasti.b_valid  = (wr_state == W_RESP);
   assign nasti.b_id     = wr_id;
   assign nasti.b_resp   = (wr_state == W_RESP) ? wr_resp : RESP_OKAY;
   assign nasti.b_user   = '0;
endmodule

// File: tb/tb_nasti_ram_sim.sv
// tb_nasti_ram_sim: directed bench for nasti_ram_sim (MEM_BYTES=4096 so that
// a burst can run off the end of memory within a 16-bit address space).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_nasti_ram_sim;
   localparam int IDW  = 1;
   localparam int AW   = 16;
   localparam int DW   = 128;
   localparam int UW   = 1;
   localparam int MEMB = 4096;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   nasti_channel #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) bus ();

   nasti_ram_sim #(
      .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW),
      .MEM_BYTES(MEMB), .READ_LAT(1)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .nasti(bus)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [DW-1:0]   wdat [16];
   logic [DW/8-1:0] wstb [16];
   logic [DW-1:0]   rdat [16];
   logic [1:0]      rresp[16];
   logic            rlast[16];
   int              rlat;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                           output logic [1:0] resp, output int lat);
      int n;
      bus.aw_id    = 1'b1;
      bus.aw_addr  = addr;
      bus.aw_len   = len;
      bus.aw_size  = size;
      bus.aw_burst = burst;
      bus.aw_valid = 1'b1;
      n = 0;
      while (!bus.aw_ready && n < 50) begin @(negedge clk); n++; end
      check("aw_accept", bus.aw_ready, 1);
      @(negedge clk);
      bus.aw_valid = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         bus.w_data  = wdat[i];
         bus.w_strb  = wstb[i];
         bus.w_last  = (i == nbeats - 1);
         bus.w_valid = 1'b1;
         n = 0;
         while (!bus.w_ready && n < 50) begin @(negedge clk); n++; end
         check("w_accept", bus.w_ready, 1);
         @(negedge clk);
      end
      bus.w_valid = 1'b0;
      bus.w_last  = 1'b0;
      lat = 1;
      while (!bus.b_valid && lat < 50) begin @(negedge clk); lat++; end
      check("b_valid", bus.b_valid, 1);
      check("b_id", bus.b_id, 1);
      resp = bus.b_resp;
      @(negedge clk);
   endtask

   // rpat is the r_ready pattern, MSB first, repeating every 4 cycles
   task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          input logic [3:0] rpat);
      int n, beat, cyc;
      logic stalled;
      logic [DW-1:0] prev;
      bus.ar_id    = 1'b1;
      bus.ar_addr  = addr;
      bus.ar_len   = len;
      bus.ar_size  = size;
      bus.ar_burst = burst;
      bus.ar_valid = 1'b1;
      n = 0;
      while (!bus.ar_ready && n < 50) begin @(negedge clk); n++; end
      check("ar_accept", bus.ar_ready, 1);
      @(negedge clk);
      bus.ar_valid = 1'b0;
      rlat = 1;
      while (!bus.r_valid && rlat < 50) begin @(negedge clk); rlat++; end
      beat = 0;
      cyc = 0;
      stalled = 1'b0;
      prev = '0;
      while (beat < nbeats && cyc < 200) begin
         if (stalled)
            check("r_stall_hold", bus.r_data, prev);
         bus.r_ready = rpat[3 - (cyc % 4)];
         if (bus.r_valid && bus.r_ready) begin
            rdat[beat]  = bus.r_data;
            rresp[beat] = bus.r_resp;
            rlast[beat] = bus.r_last;
            check("r_id", bus.r_id, 1);
            beat++;
         end
         stalled = bus.r_valid && !bus.r_ready;
         prev = bus.r_data;
         @(negedge clk);
         cyc++;
      end
      bus.r_ready = 1'b0;
      check("r_beats", beat, nbeats);
      check("r_done_idle", bus.r_valid, 0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ar_ready"}, bus.ar_ready, 1);
      check({tag, "_aw_ready"}, bus.aw_ready, 1);
      check({tag, "_r_valid"}, bus.r_valid, 0);
      check({tag, "_b_valid"}, bus.b_valid, 0);
      check({tag, "_w_ready"}, bus.w_ready, 0);
      check({tag, "_r_last"}, bus.r_last, 0);
      check({tag, "_r_resp"}, bus.r_resp, 0);
      check({tag, "_b_resp"}, bus.b_resp, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [1:0] resp;
      int lat;
      logic [DW-1:0] exp_d;

      bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0;
      bus.ar_burst = '0; bus.ar_valid = 1'b0;
      bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0;
      bus.aw_burst = '0; bus.aw_valid = 1'b0;
      bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_valid = 1'b0;
      bus.r_ready = 1'b0;
      bus.b_ready = 1'b1;

      // reset state
      repeat (3) @(negedge clk);
      check_idle("reset");
      rstn = 1'b1;
      @(negedge clk);

      // 1: single beat write and read-back
      wdat[0] = {16{8'hA5}};
      wstb[0] = '1;
      do_write(16'h0100, 8'd0, 3'd4, 2'd1, 1, resp, lat);
      check("t1_bresp", resp, 2'b00);
      check("t1_blat", lat, 1);
      do_read(16'h0100, 8'd0, 3'd4, 2'd1, 1, 4'b1111);
      check("t1_rlat", rlat, 1);
      check("t1_rdata", rdat[0], {16{8'hA5}});
      check("t1_rlast", rlast[0], 1);
      check("t1_rresp", rresp[0], 2'b00);

      // 2: INCR len3 write, read back with r_ready 1010
      for (int i = 0; i < 4; i++) begin
         wdat[i] = {4{32'hC0DE_0000 + 32'(i)}};
         wstb[i] = '1;
      end
      do_write(16'h0200, 8'd3, 3'd4, 2'd1, 4, resp, lat);
      check("t2_bresp", resp, 2'b00);
      do_read(16'h0200, 8'd3, 3'd4, 2'd1, 4, 4'b1010);
      check("t2_rlat", rlat, 1);
      for (int i = 0; i < 4; i++) begin
         check("t2_rdata", rdat[i], {4{32'hC0DE_0000 + 32'(i)}});
         check("t2_rlast", rlast[i], (i == 3));
         check("t2_rresp", rresp[i], 2'b00);
      end

      // 3: WRAP len3 from 0x230 visits 0x230,0x200,0x210,0x220
      do_read(16'h0230, 8'd3, 3'd4, 2'd2, 4, 4'b1111);
      for (int i = 0; i < 4; i++) begin
         check("t3_wrap_data", rdat[i], {4{32'hC0DE_0000 + 32'((i + 3) % 4)}});
         check("t3_wrap_resp", rresp[i], 2'b00);
      end
      do_read(16'h0200, 8'd2, 3'd4, 2'd2, 3, 4'b1111);
      for (int i = 0; i < 3; i++) begin
         check("t3_wrap2_resp", rresp[i], 2'b10);
         check("t3_wrap2_last", rlast[i], (i == 2));
      end
      do_read(16'h0100, 8'd0, 3'd4, 2'd3, 1, 4'b1111);
      check("t3_rsvd_resp", rresp[0], 2'b10);
      check("t3_rsvd_data", rdat[0], '0);

      // 4: strobed write over 0xFF pattern, FIXED read
      wdat[0] = '1;
      wstb[0] = '1;
      do_write(16'h0300, 8'd0, 3'd4, 2'd1, 1, resp, lat);
      wdat[0] = {16{8'h5A}};
      wstb[0] = 16'h000F;
      do_write(16'h0300, 8'd0, 3'd4, 2'd1, 1, resp, lat);
      check("t4_bresp", resp, 2'b00);
      exp_d = {{12{8'hFF}}, {4{8'h5A}}};
      do_read(16'h0300, 8'd3, 3'd4, 2'd0, 4, 4'b1111);
      for (int i = 0; i < 4; i++)
         check("t4_fixed_data", rdat[i], exp_d);
      check("t4_fixed_last", rlast[3], 1);

      // 5: bursts crossing the end of memory
      wstb[0] = '1;
      wdat[0] = {16{8'h11}};
      do_write(16'h0000, 8'd0, 3'd4, 2'd1, 1, resp, lat);
      wdat[0] = {16{8'h3C}};
      do_write(16'h0FF0, 8'd0, 3'd4, 2'd1, 1, resp, lat);
      do_read(16'h0FF0, 8'd1, 3'd4, 2'd1, 2, 4'b1111);
      check("t5_r0_resp", rresp[0], 2'b00);
      check("t5_r0_data", rdat[0], {16{8'h3C}});
      check("t5_r1_resp", rresp[1], 2'b11);
      check("t5_r1_data", rdat[1], '0);
      check("t5_r1_last", rlast[1], 1);
      wdat[0] = {16{8'hEE}};
      wdat[1] = {16{8'h77}};
      wstb[1] = '1;
      do_write(16'h0FF0, 8'd1, 3'd4, 2'd1, 2, resp, lat);
      check("t5_bresp", resp, 2'b11);
      do_read(16'h0000, 8'd0, 3'd4, 2'd1, 1, 4'b1111);
      check("t5_no_alias", rdat[0], {16{8'h11}});
      do_read(16'h0FF0, 8'd0, 3'd4, 2'd1, 1, 4'b1111);
      check("t5_last_word", rdat[0], {16{8'hEE}});

      // 6: reset in the middle of a read burst
      bus.ar_id = 1'b1; bus.ar_addr = 16'h0200; bus.ar_len = 8'd3;
      bus.ar_size = 3'd4; bus.ar_burst = 2'd1; bus.ar_valid = 1'b1;
      @(negedge clk);
      bus.ar_valid = 1'b0;
      bus.r_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_rd_pre_valid", bus.r_valid, 1);
      check("t6_rd_pre_data", bus.r_data, {4{32'hC0DE_0002}});
      bus.r_ready = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      check_idle("t6_rd_rst");
      rstn = 1'b1;
      @(negedge clk);

      // reset in the middle of a write burst
      bus.aw_id = 1'b1; bus.aw_addr = 16'h0400; bus.aw_len = 8'd3;
      bus.aw_size = 3'd4; bus.aw_burst = 2'd1; bus.aw_valid = 1'b1;
      @(negedge clk);
      bus.aw_valid = 1'b0;
      bus.w_data = {16{8'h99}}; bus.w_strb = '1; bus.w_last = 1'b0; bus.w_valid = 1'b1;
      check("t6_wr_pre_ready", bus.w_ready, 1);
      @(negedge clk);
      bus.w_valid = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      check_idle("t6_wr_rst");
      rstn = 1'b1;
      @(negedge clk);

      wdat[0] = {16{8'h42}};
      wstb[0] = '1;
      do_write(16'h0400, 8'd0, 3'd4, 2'd1, 1, resp, lat);
      check("t6_post_bresp", resp, 2'b00);
      check("t6_post_blat", lat, 1);
      do_read(16'h0400, 8'd0, 3'd4, 2'd1, 1, 4'b1111);
      check("t6_post_rdata", rdat[0], {16{8'h42}});
      check("t6_post_rlast", rlast[0], 1);
      check("t6_post_rlat", rlat, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
